// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encodings and screen coordinate width.
package game_pkg;
  localparam int COORD_W = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;
endpackage

// File: rtl/box_overlap.sv
// Combinational clamp of a wrapped obstacle box plus a strict AABB overlap test.
module box_overlap
  import game_pkg::*;
#(
  parameter int D_WIDTH = 640
) (
  input  logic [COORD_W-1:0] i_px1,
  input  logic [COORD_W-1:0] i_px2,
  input  logic [COORD_W-1:0] i_py1,
  input  logic [COORD_W-1:0] i_py2,
  input  logic [COORD_W-1:0] i_ox1,
  input  logic [COORD_W-1:0] i_ox2,
  input  logic [COORD_W-1:0] i_oy1,
  input  logic [COORD_W-1:0] i_oy2,
  output logic [COORD_W-1:0] o_eff_ox1,
  output logic [COORD_W-1:0] o_eff_ox2,
  output logic               o_overlap
);
  localparam logic [COORD_W-1:0] OX2_MAX = COORD_W'(D_WIDTH + 255);

  // A left edge that underflowed past 0 wraps to a huge value; pin it to 0.
  always_comb begin
    o_eff_ox1 = (i_ox1 > i_ox2) ? '0 : i_ox1;
    o_eff_ox2 = (i_ox2 > OX2_MAX) ? '0 : i_ox2;
    o_overlap = (i_px1 < o_eff_ox2) & (o_eff_ox1 < i_px2) &
                (i_py1 < i_oy2) & (i_oy1 < i_py2);
  end
endmodule

// File: rtl/collision_ctrl.sv
// Game control: per-frame collision debounce, obstacle pass scoring and game FSM,
// driving the obstacle animator's enable and reset.
module collision_ctrl
  import game_pkg::*;
#(
  parameter int D_WIDTH     = 640,
  parameter int HIT_FRAMES  = 2,
  parameter int OVER_FRAMES = 120,
  parameter int SCORE_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_stb,
  input  logic               i_start,
  input  logic [11:0]        i_px1,
  input  logic [11:0]        i_px2,
  input  logic [11:0]        i_py1,
  input  logic [11:0]        i_py2,
  input  logic [11:0]        i_ox1,
  input  logic [11:0]        i_ox2,
  input  logic [11:0]        i_oy1,
  input  logic [11:0]        i_oy2,
  output logic               o_animate,
  output logic               o_obs_rst,
  output logic               o_hit,
  output logic               o_game_over,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_state
);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]         HIT_LAST  = 4'(HIT_FRAMES);
  localparam logic [7:0]         OVER_LAST = 8'(OVER_FRAMES);

  logic [1:0]         state_q, state_d;
  logic               start_prev_q, start_prev_d;
  logic [3:0]         hit_cnt_q, hit_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [11:0]        prev_ox1_q, prev_ox1_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               animate_q, animate_d;
  logic               obs_rst_q, obs_rst_d;
  logic               hit_q, hit_d;
  logic               over_q, over_d;

  logic [11:0] eff_ox1;
  logic [11:0] eff_ox2;
  logic        overlap;
  logic        start_rise;
  logic        pass;

  box_overlap #(.D_WIDTH(D_WIDTH)) u_box_overlap (
    .i_px1     (i_px1),
    .i_px2     (i_px2),
    .i_py1     (i_py1),
    .i_py2     (i_py2),
    .i_ox1     (i_ox1),
    .i_ox2     (i_ox2),
    .i_oy1     (i_oy1),
    .i_oy2     (i_oy2),
    .o_eff_ox1 (eff_ox1),
    .o_eff_ox2 (eff_ox2),
    .o_overlap (overlap)
  );

  assign start_rise = i_start & ~start_prev_q;
  // The obstacle's left edge just crossed the player's right edge this frame.
  assign pass = (prev_ox1_q <= i_px2) & (eff_ox1 > i_px2);

  always_comb begin
    state_d      = state_q;
    start_prev_d = i_start;
    hit_cnt_d    = hit_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    prev_ox1_d   = prev_ox1_q;
    score_d      = score_q;
    obs_rst_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d    = ST_PLAY;
          obs_rst_d  = 1'b1;
          score_d    = '0;
          hit_cnt_d  = '0;
          prev_ox1_d = eff_ox1;
        end
      end
      ST_PLAY: begin
        if (i_frame_stb) begin
          prev_ox1_d = eff_ox1;
          if (overlap) begin
            hit_cnt_d = hit_cnt_q + 4'd1;
            if (hit_cnt_q + 4'd1 == HIT_LAST) begin
              state_d     = ST_HIT;
              frame_cnt_d = '0;
            end
          end else begin
            hit_cnt_d = '0;
            if (pass && (score_q != SCORE_MAX)) score_d = score_q + 1'b1;
          end
        end
      end
      ST_HIT: begin
        if (i_frame_stb) begin
          if (frame_cnt_q + 8'd1 == OVER_LAST) state_d = ST_OVER;
          else frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    animate_d = (state_d == ST_PLAY);
    hit_d     = (state_d == ST_HIT);
    over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;
      hit_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      prev_ox1_q   <= '0;
      score_q      <= '0;
      animate_q    <= 1'b0;
      obs_rst_q    <= 1'b0;
      hit_q        <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      prev_ox1_q   <= prev_ox1_d;
      score_q      <= score_d;
      animate_q    <= animate_d;
      obs_rst_q    <= obs_rst_d;
      hit_q        <= hit_d;
      over_q       <= over_d;
    end
  end

  assign o_state     = state_q;
  assign o_score     = score_q;
  assign o_animate   = animate_q;
  assign o_obs_rst   = obs_rst_q;
  assign o_hit       = hit_q;
  assign o_game_over = over_q;
endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Game-control stage directly downstream of the obstacle animator; consumes its edge outputs plus the player box edges.
- Samples overlap once per frame, debounces collisions, counts obstacles passed, and runs the game FSM.
- Drives the animator's animate-enable and a one-cycle obstacle reset pulse, closing the loop with the upstream stage.

Parameters:
- D_WIDTH, 640: display width; used for the wrapped-edge clamp.
- HIT_FRAMES, 2: consecutive overlapping frames needed to declare a hit (1..15).
- OVER_FRAMES, 120: frames spent in HIT (flash) before entering OVER (1..255).
- SCORE_W, 8: score width; score saturates at 2^SCORE_W-1.

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- i_frame_stb  in  1  one-cycle pulse at end of active video; the only sample point
- i_start  in  1  start button, synchronous level
- i_px1, i_px2, i_py1, i_py2  in  12 each  player left/right/top/bottom edges
- i_ox1, i_ox2, i_oy1, i_oy2  in  12 each  obstacle left/right/top/bottom edges (from animator)
- o_animate  out  1  animate enable to obstacle animator
- o_obs_rst  out  1  one-cycle reset pulse to obstacle animator
- o_hit  out  1  high in HIT state
- o_game_over  out  1  high in OVER state
- o_score  out  SCORE_W  obstacles passed this game
- o_state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3

Behaviour:
- Reset values: state IDLE; all outputs 0; hit_cnt=0; frame_cnt=0; prev_ox1=0.
- start_prev resets to 1, so a button held through reset produces no edge.
- start_rise = i_start & ~start_prev; start_prev is updated every cycle.
- Wrapped-edge clamp: if i_ox1 > i_ox2 (unsigned underflow at the left edge), eff_ox1 = 0; otherwise eff_ox1 = i_ox1.
  - if i_ox2 > D_WIDTH+255, eff_ox2 = 0; otherwise eff_ox2 = i_ox2.
- overlap = (i_px1 < eff_ox2) & (eff_ox1 < i_px2) & (i_py1 < i_oy2) & (i_oy1 < i_py2); strict compares, so touching edges do not overlap. Combinational; only sampled on i_frame_stb.
- pass = (prev_ox1 <= i_px2) & (eff_ox1 > i_px2). prev_ox1 <= eff_ox1 on every i_frame_stb while in PLAY.
- All register updates take effect on the clock edge of the i_frame_stb cycle; outputs are registered (visible the following cycle).
- IDLE:
  - o_animate=0.
  - On start_rise: go to PLAY, pulse o_obs_rst for 1 cycle, clear score, clear hit_cnt, load prev_ox1 <= eff_ox1.
- PLAY:
  - o_animate=1.
  - On i_frame_stb with overlap: hit_cnt++. When hit_cnt+1 == HIT_FRAMES, go to HIT and clear frame_cnt.
  - On i_frame_stb without overlap: hit_cnt=0.
  - On pass with no overlap in the same frame: score++, saturating at max.
  - Overlap and pass in the same frame: overlap wins, no score.
- HIT:
  - o_animate=0, o_hit=1.
  - frame_cnt++ per i_frame_stb; at OVER_FRAMES go to OVER.
  - i_start ignored.
- OVER:
  - o_game_over=1, o_animate=0; score held.
  - On start_rise: go to PLAY with the same actions as IDLE->PLAY (o_obs_rst pulse, score cleared).
- o_obs_rst is exactly 1 cycle and asserted only on entry to PLAY.
- i_frame_stb in the same cycle as start_rise in IDLE: the transition happens; no sampling that frame.
- i_rst mid-game: next cycle is IDLE with all outputs 0; score lost.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package game_pkg: state encodings (ST_IDLE..ST_OVER, 2-bit), COORD_W=12.
- One sub-module, box_overlap: purely combinational edge clamp plus strict AABB compare, reusable by the renderer for pixel tests.
- FSM, counters and start edge detect stay in collision_ctrl.

Test Plan:
- Reset, then i_start held high -> state stays IDLE (no edge). Release and press -> o_obs_rst high exactly 1 cycle, o_state=1, o_animate=1.
- Player (100,200,100,140), obstacle ox1=150, ox2=190 stepping +1 per frame_stb -> o_score goes 0->1 on the frame ox1 becomes 201, and never increments again while past.
- Overlap boxes for exactly 1 frame with HIT_FRAMES=2 -> stays PLAY, hit_cnt returns to 0. Overlap 2 consecutive frames -> o_hit=1 and o_animate=0 one cycle after the 2nd strobe.
- Touching edges (i_px2 == i_ox1) for 10 frames -> no hit.
- Wrapped obstacle: i_ox1=4090, i_ox2=10, player px1=0, px2=20, overlapping in y -> overlap detected (clamp works). After HIT_FRAMES plus OVER_FRAMES=3 strobes -> o_game_over=1. start_rise -> PLAY, score=0.
- Score at 255 (SCORE_W=8) plus one more pass -> stays 255. Assert i_rst mid-PLAY -> next cycle all outputs 0, o_state=0.
